code_converter_seq: RTL
=======================

// Module: code_converter_seq
// PURPOSE
//  Parametrised, handshaked multi-digit code converter: binary/Gray/BCD/Excess-3 over WIDTH-bit binary and DIGITS-digit BCD/XS3.
//  Iterative double-dabble (bin->BCD) and multiply-accumulate (BCD->bin) datapaths; valid/ready on both sides.
//  Sits between data sources and display/serial encoders; one conversion in flight at a time.
// PARAMETERS
//  WIDTH   8   binary operand width (Gray modes also use WIDTH bits)
//  DIGITS  3   BCD/XS3 digit count; constraint 10**DIGITS > 2**WIDTH-1 (elaboration-time check, $error on violation)
//  DW      4*DIGITS  derived bus width (localparam, not overridable)
// PORTS
//  clk       in   1       rising-edge clock
//  rst_n     in   1       async active-low reset
//  in_valid  in   1       request valid
//  in_ready  out  1       block can accept (state==IDLE)
//  mode      in   3       conversion select, sampled at accept
//  data_in   in   DW      operand; binary/Gray modes use [WIDTH-1:0], upper bits ignored
//  out_valid out  1       result valid, held until out_ready
//  out_ready in   1       consumer accepts result
//  data_out  out  DW      result; binary/Gray results zero-extended to DW
//  err       out  1       qualifies data_out with out_valid: invalid input or overflow (data_out=0)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, data_out=0, err=0, all work regs 0; in_ready=1 (combinational from IDLE).
//  Reset mid-conversion aborts immediately; no partial result ever appears.
//  Modes: 000 bin->Gray, 001 Gray->bin, 010 bin->BCD, 011 BCD->XS3, 100 bin->XS3, 101 XS3->BCD, 110 XS3->bin, 111 BCD->bin.
//  FSM IDLE->CALC->DONE->IDLE.
//   IDLE: accept when in_valid&in_ready (edge k); latch mode/data_in; validate; go CALC.
//   CALC: N cycles; single-step modes (000,001,011,101) and any error N=1; 010/100 N=WIDTH; 111/110 N=DIGITS.
//   DONE: out_valid=1 from edge k+N; data_out/err stable until out_valid&out_ready, then IDLE (in_ready=1 next cycle, no same-cycle re-accept).
//  Validation at accept: any BCD digit >9 (011,111) or XS3 digit <3 or >12 (101,110) -> err=1, data_out=0, N=1.
//  Gray->bin: prefix XOR MSB-down; bin->Gray: b^(b>>1).
//  bin->BCD: double dabble, per cycle add 3 to each digit >=5 then shift left 1; WIDTH cycles.
//  bin->XS3: bin->BCD then +3 per digit applied when result is registered (no extra cycle).
//  BCD->bin: MSD-first acc = acc*10 + digit, one digit/cycle, acc WIDTH+4 bits; final acc > 2**WIDTH-1 -> err=1, data_out=0.
//  XS3->bin: -3 per digit at accept, then BCD->bin path.
//  Per-digit +/-3 never carries between digits (validated range).
//  in_valid while busy ignored (in_ready=0); mode/data_in changes after accept have no effect.
// STRUCTURE
//  Package code_conv_pkg: mode localparams (MODE_B2G..MODE_BCD2B), FSM state encoding, digit add3/sub3 functions.
//  Sub-module dd_step: one combinational double-dabble iteration over DIGITS digits + WIDTH-bit shift reg, instanced once.
//  Top holds FSM, cycle counter ($clog2(WIDTH+1) bits), MAC accumulator, output registers.
// TESTING
//  1 mode=000 data_in=8'hB4 -> data_out=8'hEE, err=0, out_valid one cycle after accept; mode=001 8'hEE -> 8'hB4.
//  2 mode=010 data_in=8'd255 -> 12'h255 at edge k+8; mode=100 8'd255 -> 12'h588; mode=010 0 -> 12'h000.
//  3 mode=111 12'h173 -> 8'hAD at edge k+3; 12'h256 -> err=1, data_out=0 (overflow); mode=110 12'h4A6 -> 8'hAD.
//  4 mode=011 12'h129 -> 12'h45C; 12'h09A -> err=1; mode=101 12'h3C2 -> err=1 (digit 2<3).
//  5 Hold out_ready=0 5 cycles with in_valid=1 -> data_out/err stable, in_ready=0, no second accept; release -> one handshake, IDLE.
//  6 Assert rst_n=0 mid mode 010 -> out_valid/data_out/err 0 asynchronously; after release, 8'd99 -> 12'h099.

Source files
------------

// File: rtl/code_converter_seq_pkg.sv
// Shared definitions for the multi-digit code converter: mode codes, FSM
// encoding and per-digit BCD/XS3 helpers.
package code_conv_pkg;

    localparam logic [2:0] MODE_B2G     = 3'b000;
    localparam logic [2:0] MODE_G2B     = 3'b001;
    localparam logic [2:0] MODE_B2BCD   = 3'b010;
    localparam logic [2:0] MODE_BCD2XS3 = 3'b011;
    localparam logic [2:0] MODE_B2XS3   = 3'b100;
    localparam logic [2:0] MODE_XS32BCD = 3'b101;
    localparam logic [2:0] MODE_XS32B   = 3'b110;
    localparam logic [2:0] MODE_BCD2B   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return d + 4'd3;
    endfunction

    function automatic logic [3:0] sub3(input logic [3:0] d);
        return d - 4'd3;
    endfunction

    // Double-dabble correction: a digit >= 5 would exceed 9 after the shift.
    function automatic logic [3:0] dd_adj(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    function automatic logic bcd_bad(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    function automatic logic xs3_bad(input logic [3:0] d);
        return (d < 4'd3) || (d > 4'd12);
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/code_converter_seq_if.sv
// Request/response handshake bundle between a data source, the converter and
// its consumer.
interface code_converter_seq_if #(
    parameter int DW = 12
) ();
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    mode;
    logic [DW-1:0] data_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] data_out;
    logic          err;

    modport master (
        output in_valid, mode, data_in, out_ready,
        input  in_ready, out_valid, data_out, err
    );

    modport slave (
        input  in_valid, mode, data_in, out_ready,
        output in_ready, out_valid, data_out, err
    );
endinterface

// File: rtl/code_converter_seq_dd_step.sv
// One combinational double-dabble iteration: correct every BCD digit, then
// shift the BCD/binary pair left by one bit.
module dd_step
    import code_conv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] bcd_i,
    input  logic [WIDTH-1:0]    bin_i,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic [WIDTH-1:0]    bin_o
);
    localparam int DW = 4 * DIGITS;

    logic [DW-1:0] adj;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj[4*gi +: 4] = dd_adj(bcd_i[4*gi +: 4]);
        end
    endgenerate

    assign bcd_o = {adj[DW-2:0], bin_i[WIDTH-1]};
    assign bin_o = {bin_i[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/code_converter_seq.sv
// Handshaked binary/Gray/BCD/XS3 converter. One conversion in flight; iterative
// double-dabble for bin->BCD and MSD-first multiply-accumulate for BCD->bin.
module code_converter_seq
    import code_conv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic clk,
    input  logic rst_n,
    code_converter_seq_if.slave bus
);
    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = WIDTH + 4;
    localparam int MW = WIDTH + 8;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_BIN = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_DIG = CW'(DIGITS);
    localparam logic [MW-1:0] MAX_BIN = MW'((64'd1 << WIDTH) - 64'd1);

    generate
        if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_range_chk
            $error("code_converter_seq: DIGITS too small to hold 2**WIDTH-1");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [2:0]      mode_q, mode_d;
    logic [DW-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [DW-1:0]   bcd_q, bcd_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            ovf_q, ovf_d;
    logic            bad_q, bad_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   data_out_q, data_out_d;
    logic            err_q, err_d;

    logic [DIGITS-1:0] in_bcd_bad, in_xs3_bad;
    logic [DW-1:0]     in_sub3, op_add3, op_sub3, dd_xs3;
    logic [DW-1:0]     dd_bcd;
    logic [WIDTH-1:0]  dd_bin;
    logic [WIDTH-1:0]  g2b;
    logic [MW-1:0]     acc_full;
    logic              acc_over;

    dd_step #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_dd_step (
        .bcd_i (bcd_q),
        .bin_i (bin_q),
        .bcd_o (dd_bcd),
        .bin_o (dd_bin)
    );

    // Per-digit +/-3 never carries: inputs are range-checked before use.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign in_bcd_bad[gi]     = bcd_bad(bus.data_in[4*gi +: 4]);
            assign in_xs3_bad[gi]     = xs3_bad(bus.data_in[4*gi +: 4]);
            assign in_sub3[4*gi +: 4] = sub3(bus.data_in[4*gi +: 4]);
            assign op_add3[4*gi +: 4] = add3(opnd_q[4*gi +: 4]);
            assign op_sub3[4*gi +: 4] = sub3(opnd_q[4*gi +: 4]);
            assign dd_xs3[4*gi +: 4]  = add3(dd_bcd[4*gi +: 4]);
        end
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gray
            assign g2b[gi] = ^opnd_q[WIDTH-1:gi];
        end
    endgenerate

    assign acc_full = MW'(acc_q) * MW'(10) + MW'(opnd_q[DW-1 -: 4]);
    assign acc_over = ovf_q || (acc_full > MAX_BIN);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        opnd_d     = opnd_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        bad_d      = bad_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        err_d      = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_CALC;
                    mode_d  = bus.mode;
                    opnd_d  = bus.data_in;
                    bin_d   = bus.data_in[WIDTH-1:0];
                    bcd_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    bad_d   = 1'b0;
                    cnt_d   = CNT_ONE;
                    unique case (bus.mode)
                        MODE_B2BCD, MODE_B2XS3: cnt_d = CNT_BIN;
                        MODE_BCD2XS3:           bad_d = |in_bcd_bad;
                        MODE_XS32BCD:           bad_d = |in_xs3_bad;
                        MODE_BCD2B: begin
                            bad_d = |in_bcd_bad;
                            cnt_d = (|in_bcd_bad) ? CNT_ONE : CNT_DIG;
                        end
                        MODE_XS32B: begin
                            bad_d  = |in_xs3_bad;
                            opnd_d = in_sub3;
                            cnt_d  = (|in_xs3_bad) ? CNT_ONE : CNT_DIG;
                        end
                        default: ;
                    endcase
                end
            end

            ST_CALC: begin
                cnt_d = cnt_q - CNT_ONE;
                if (mode_q == MODE_B2BCD || mode_q == MODE_B2XS3) begin
                    bin_d = dd_bin;
                    bcd_d = dd_bcd;
                end
                if (mode_q == MODE_BCD2B || mode_q == MODE_XS32B) begin
                    acc_d  = acc_full[AW-1:0];
                    opnd_d = {opnd_q[DW-5:0], 4'h0};
                    ovf_d  = acc_over;
                end
                // Last iteration: commit the result straight from the step logic.
                if (cnt_q == CNT_ONE) begin
                    state_d    = ST_DONE;
                    err_d      = 1'b0;
                    data_out_d = '0;
                    if (bad_q) begin
                        err_d = 1'b1;
                    end else begin
                        unique case (mode_q)
                            MODE_B2G:     data_out_d = DW'(opnd_q[WIDTH-1:0] ^ (opnd_q[WIDTH-1:0] >> 1));
                            MODE_G2B:     data_out_d = DW'(g2b);
                            MODE_B2BCD:   data_out_d = dd_bcd;
                            MODE_B2XS3:   data_out_d = dd_xs3;
                            MODE_BCD2XS3: data_out_d = op_add3;
                            MODE_XS32BCD: data_out_d = op_sub3;
                            default: begin
                                if (acc_over) begin
                                    err_d = 1'b1;
                                end else begin
                                    data_out_d = DW'(acc_full[WIDTH-1:0]);
                                end
                            end
                        endcase
                    end
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            opnd_q     <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            bad_q      <= 1'b0;
            cnt_q      <= '0;
            data_out_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            opnd_q     <= opnd_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            bad_q      <= bad_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.data_out  = data_out_q;
    assign bus.err       = err_q;

endmodule
